// File: rtl/qa_drv_hc_write_arbiter_rr.sv
// rtl/qa_drv_hc_write_arbiter_rr.sv - N-way TX C1 write arbiter, optional strict-priority req[0], round-robin rest, starvation guard
module qa_drv_hc_write_arbiter_rr #(
    parameter int N_REQ        = 4,
    parameter int HDR_W        = 61,
    parameter int DATA_W       = 512,
    parameter int HIPRI_EN     = 1,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*HDR_W-1:0]    req_hdr,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          grant,
    output logic                      can_issue,
    output logic [HDR_W-1:0]          tx_hdr,
    output logic [DATA_W-1:0]         tx_data,
    output logic                      tx_wrvalid,
    input  logic                      tx_almostfull
);

    // RR set is indices BASE..N_REQ-1; rr_ptr is an offset within that set
    localparam bit HIPRI = (HIPRI_EN != 0);
    localparam int BASE  = HIPRI ? 1 : 0;
    localparam int RR_N  = N_REQ - BASE;
    localparam int PTR_W = (RR_N > 1) ? $clog2(RR_N) : 1;
    localparam bit GUARD = HIPRI && (STARVE_LIMIT > 0);
    localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  win_off;
    logic              rr_found;
    logic [CNT_W-1:0]  starve_cnt;
    logic              force_rr;
    logic              rr_any;
    logic              rr_win;
    logic [HDR_W-1:0]  sel_hdr;
    logic [DATA_W-1:0] sel_data;

    assign force_rr = GUARD && (starve_cnt == CNT_W'(STARVE_LIMIT));

    // Issue permission follows almost-full with one cycle of lag
    always_ff @(posedge clk) begin
        if (!reset_n) can_issue <= 1'b0;
        else          can_issue <= !tx_almostfull;
    end

    // Grant selection: strict req[0] unless forced, else RR scan from rr_ptr
    always_comb begin
        int off;
        grant    = '0;
        rr_found = 1'b0;
        win_off  = '0;
        off      = 0;
        if (reset_n && can_issue) begin
            if (HIPRI && req[0] && !force_rr) begin
                grant[0] = 1'b1;
            end else begin
                for (int j = 0; j < RR_N; j++) begin
                    off = (int'(rr_ptr) + j) % RR_N;
                    if (!rr_found && req[BASE + off]) begin
                        rr_found          = 1'b1;
                        grant[BASE + off] = 1'b1;
                        win_off           = PTR_W'(off);
                    end
                end
                if (!rr_found && HIPRI && req[0]) grant[0] = 1'b1;
            end
        end
    end

    // Pending / granted summaries over the RR set
    always_comb begin
        rr_any = 1'b0;
        rr_win = 1'b0;
        for (int i = BASE; i < N_REQ; i++) begin
            rr_any = rr_any | req[i];
            rr_win = rr_win | grant[i];
        end
    end

    // Advance the RR pointer past the winner only on an RR grant
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_ptr <= '0;
        end else if (rr_found) begin
            if (int'(win_off) == RR_N - 1) rr_ptr <= '0;
            else                           rr_ptr <= win_off + PTR_W'(1);
        end
    end

    // Count req[0] wins while RR requestors wait; saturate to force an RR turn
    always_ff @(posedge clk) begin
        if (!reset_n || !GUARD) begin
            starve_cnt <= '0;
        end else if (rr_win || !rr_any) begin
            starve_cnt <= '0;
        end else if (grant[0] && (starve_cnt != CNT_W'(STARVE_LIMIT))) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    // One-hot mux of the granted requestor's header and data
    always_comb begin
        sel_hdr  = '0;
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_hdr  = sel_hdr  | req_hdr[i*HDR_W +: HDR_W];
                sel_data = sel_data | req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Register the winning write onto TX C1; payload holds when idle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx_wrvalid <= 1'b0;
            tx_hdr     <= '0;
            tx_data    <= '0;
        end else begin
            tx_wrvalid <= |grant;
            if (|grant) begin
                tx_hdr  <= sel_hdr;
                tx_data <= sel_data;
            end
        end
    end

endmodule

// File: tb/tb_qa_drv_hc_write_arbiter_rr.sv
// tb/tb_qa_drv_hc_write_arbiter_rr.sv - directed vector bench for qa_drv_hc_write_arbiter_rr
module tb_qa_drv_hc_write_arbiter_rr;

    localparam int N  = 4;
    localparam int HW = 16;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: strict-priority req[0], starvation guard 8
    logic              reset_n;
    logic [N-1:0]      req;
    logic [N*HW-1:0]   req_hdr;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      grant;
    logic              can_issue;
    logic [HW-1:0]     tx_hdr;
    logic [DW-1:0]     tx_data;
    logic              tx_wrvalid;
    logic              tx_af;

    // DUT B: all requestors round-robin
    logic              reset_n_b;
    logic [N-1:0]      req_b;
    logic [N*HW-1:0]   hdr_b;
    logic [N*DW-1:0]   data_b;
    logic [N-1:0]      grant_b;
    logic              can_b;
    logic [HW-1:0]     tx_hdr_b;
    logic [DW-1:0]     tx_data_b;
    logic              wrv_b;
    logic              af_b;

    qa_drv_hc_write_arbiter_rr #(.N_REQ(N), .HDR_W(HW), .DATA_W(DW), .HIPRI_EN(1), .STARVE_LIMIT(8)) u_a (
        .clk(clk), .reset_n(reset_n), .req(req), .req_hdr(req_hdr), .req_data(req_data),
        .grant(grant), .can_issue(can_issue), .tx_hdr(tx_hdr), .tx_data(tx_data),
        .tx_wrvalid(tx_wrvalid), .tx_almostfull(tx_af)
    );

    qa_drv_hc_write_arbiter_rr #(.N_REQ(N), .HDR_W(HW), .DATA_W(DW), .HIPRI_EN(0), .STARVE_LIMIT(8)) u_b (
        .clk(clk), .reset_n(reset_n_b), .req(req_b), .req_hdr(hdr_b), .req_data(data_b),
        .grant(grant_b), .can_issue(can_b), .tx_hdr(tx_hdr_b), .tx_data(tx_data_b),
        .tx_wrvalid(wrv_b), .tx_almostfull(af_b)
    );

    typedef struct {
        logic [N-1:0] req;
        logic         af;
        logic [N-1:0] g;
    } vec_t;

    vec_t tab[$];
    vec_t tab_b[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic [N-1:0] r, input logic a, input logic [N-1:0] g, input int times);
        for (int k = 0; k < times; k++) tab.push_back('{req: r, af: a, g: g});
    endfunction

    function automatic void add_b(input logic [N-1:0] r, input logic [N-1:0] g);
        tab_b.push_back('{req: r, af: 1'b0, g: g});
    endfunction

    function automatic logic [HW-1:0] hval(input int row, input int i);
        return HW'(row * 256 + i);
    endfunction

    function automatic logic [DW-1:0] dval(input int row, input int i);
        return 32'hD000_0000 + DW'(row * 16 + i);
    endfunction

    task automatic fill(input int row);
        for (int i = 0; i < N; i++) begin
            req_hdr[i*HW +: HW]  = hval(row, i);
            req_data[i*DW +: DW] = dval(row, i);
            hdr_b[i*HW +: HW]    = hval(row, i);
            data_b[i*DW +: DW]   = dval(row, i);
        end
    endtask

    function automatic int idx_of(input logic [N-1:0] g);
        int r;
        r = 0;
        for (int i = 0; i < N; i++) if (g[i]) r = i;
        return r;
    endfunction

    initial begin
        logic [HW-1:0] exp_hdr;
        logic [DW-1:0] exp_data;
        logic          prev_v;
        logic          prev_af;

        // idle, then strict-priority-free RR rotation
        add(4'b0000, 1'b0, 4'b0000, 3);
        for (int k = 0; k < 2; k++) begin
            add(4'b1110, 1'b0, 4'b0010, 1);
            add(4'b1110, 1'b0, 4'b0100, 1);
            add(4'b1110, 1'b0, 4'b1000, 1);
        end
        // starvation guard: 8 req[0] wins, one forced RR, and again after clear
        add(4'b0011, 1'b0, 4'b0001, 8);
        add(4'b0011, 1'b0, 4'b0010, 1);
        add(4'b0011, 1'b0, 4'b0001, 8);
        add(4'b0011, 1'b0, 4'b0010, 1);
        add(4'b0000, 1'b0, 4'b0000, 1);
        // almost-full for 5 cycles
        add(4'b0100, 1'b0, 4'b0100, 1);
        add(4'b0100, 1'b1, 4'b0100, 1);
        add(4'b0100, 1'b1, 4'b0000, 4);
        add(4'b0100, 1'b0, 4'b0000, 1);
        add(4'b0100, 1'b0, 4'b0100, 1);
        add(4'b0000, 1'b0, 4'b0000, 1);

        add_b(4'b1111, 4'b0001);
        add_b(4'b1111, 4'b0010);
        add_b(4'b1111, 4'b0100);
        add_b(4'b1111, 4'b1000);
        add_b(4'b1111, 4'b0001);
        add_b(4'b1011, 4'b0010);
        add_b(4'b1011, 4'b1000);
        add_b(4'b1011, 4'b0001);
        add_b(4'b1011, 4'b0010);
        add_b(4'b0000, 4'b0000);

        // reset with all requests high: grant must stay zero
        reset_n   = 1'b0;
        reset_n_b = 1'b0;
        req       = 4'b1111;
        req_b     = 4'b0000;
        tx_af     = 1'b0;
        af_b      = 1'b0;
        fill(0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_grant", 64'(grant), 64'h0);
        chk("reset_can_issue", 64'(can_issue), 64'h0);
        chk("reset_wrvalid", 64'(tx_wrvalid), 64'h0);
        chk("reset_hdr", 64'(tx_hdr), 64'h0);
        chk("reset_data", 64'(tx_data), 64'h0);
        reset_n   = 1'b1;
        reset_n_b = 1'b1;

        exp_hdr  = '0;
        exp_data = '0;
        prev_v   = 1'b0;
        prev_af  = 1'b0;
        for (int r = 0; r < tab.size(); r++) begin
            @(posedge clk);
            #1;
            chk($sformatf("a_wrvalid[%0d]", r), 64'(tx_wrvalid), 64'(prev_v));
            chk($sformatf("a_hdr[%0d]", r), 64'(tx_hdr), 64'(exp_hdr));
            chk($sformatf("a_data[%0d]", r), 64'(tx_data), 64'(exp_data));
            chk($sformatf("a_can_issue[%0d]", r), 64'(can_issue), 64'(!prev_af));
            req   = tab[r].req;
            tx_af = tab[r].af;
            fill(r);
            #1;
            chk($sformatf("a_grant[%0d]", r), 64'(grant), 64'(tab[r].g));
            prev_v  = |tab[r].g;
            prev_af = tab[r].af;
            if (prev_v) begin
                exp_hdr  = hval(r, idx_of(tab[r].g));
                exp_data = dval(r, idx_of(tab[r].g));
            end
        end

        // all-RR instance: rotation, and a dropped requestor is skipped without a bubble
        prev_v = 1'b0;
        for (int r = 0; r < tab_b.size(); r++) begin
            @(posedge clk);
            #1;
            chk($sformatf("b_wrvalid[%0d]", r), 64'(wrv_b), 64'(prev_v));
            req_b = tab_b[r].req;
            fill(200 + r);
            #1;
            chk($sformatf("b_grant[%0d]", r), 64'(grant_b), 64'(tab_b[r].g));
            prev_v = |tab_b[r].g;
        end

        // one-cycle reset during continuous grants restarts RR at index 1
        @(posedge clk);
        #1;
        req = 4'b1110;
        fill(100);
        #1;
        chk("rst_pre_grant0", 64'(grant), 64'b1000);
        @(posedge clk);
        #1;
        chk("rst_pre_wrvalid", 64'(tx_wrvalid), 64'h1);
        chk("rst_pre_hdr", 64'(tx_hdr), 64'(hval(100, 3)));
        fill(101);
        #1;
        chk("rst_pre_grant1", 64'(grant), 64'b0010);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("rst_grant_suppressed", 64'(grant), 64'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk("rst_wrvalid", 64'(tx_wrvalid), 64'h0);
        chk("rst_can_issue", 64'(can_issue), 64'h0);
        chk("rst_hdr", 64'(tx_hdr), 64'h0);
        #1;
        chk("rst_grant_blocked", 64'(grant), 64'h0);
        @(posedge clk);
        #1;
        chk("rst_can_back", 64'(can_issue), 64'h1);
        chk("rst_wrvalid_idle", 64'(tx_wrvalid), 64'h0);
        fill(102);
        #1;
        chk("rst_restart_idx1", 64'(grant), 64'b0010);
        @(posedge clk);
        #1;
        chk("rst_restart_hdr", 64'(tx_hdr), 64'(hval(102, 1)));
        chk("rst_restart_wrvalid", 64'(tx_wrvalid), 64'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/qa_drv_hc_write_arbiter_rr.md
Name: qa_drv_hc_write_arbiter_rr

Overview:
Parametrised N-way write arbiter for the host-channel TX C1 write path. It selects one write request per cycle from N_REQ requestors, for example the status manager, frame reader, frame writer and extra channels. Requestor 0 can optionally be a strict high-priority source. The remaining requestors share round-robin arbitration with a starvation guard, and the winning header/data is registered onto the TX C1 interface under almost-full flow control.

Parameters:
N_REQ, 4, number of requestors (2..16)
HDR_W, 61, TX header width in bits
DATA_W, 512, write data width in bits
HIPRI_EN, 1, 1 = requestor 0 has strict priority; 0 = all requestors are round-robin
STARVE_LIMIT, 8, consecutive req[0] grants allowed while an RR requestor waits; 0 = guard disabled

Ports:
clk  in  1  clock
reset_n  in  1  synchronous, active-low reset
req  in  N_REQ  per-requestor write request (level)
req_hdr  in  N_REQ*HDR_W  packed headers; slice i belongs to requestor i
req_data  in  N_REQ*DATA_W  packed data; slice i belongs to requestor i
grant  out  N_REQ  one-hot or zero grant, combinational, same cycle as req
can_issue  out  1  registered issue permission, exported to requestors
tx_hdr  out  HDR_W  registered header to TX C1
tx_data  out  DATA_W  registered data to TX C1
tx_wrvalid  out  1  registered write valid to TX C1
tx_almostfull  in  1  TX C1 almost-full back-pressure

Behaviour:
- Clock and reset: clk is the only clock. reset_n is synchronous and active-low.
- Reset values: can_issue=0, tx_wrvalid=0, tx_hdr=0, tx_data=0, rr_ptr=0, starve_cnt=0. While reset_n=0, grant=0.
- can_issue is registered: can_issue <= !tx_almostfull. Its effect on grant therefore lags tx_almostfull by 1 cycle. TX C1 must absorb at least 2 writes after almost-full asserts.
- Grant is combinational and is always 0 when can_issue=0.
- Grant selection when can_issue=1:
  - If HIPRI_EN=1, req[0]=1 and force_rr=0: grant[0]=1.
  - Otherwise, scan the RR set (indices 1..N_REQ-1, or 0..N_REQ-1 when HIPRI_EN=0) starting at rr_ptr, wrapping modulo the set. Grant the first requester found.
  - If HIPRI_EN=1, force_rr=1 and no RR requestor is asserting req, req[0] is granted.
- Grant is at most one-hot in every cycle; two set bits is an error.
- rr_ptr update: on an RR grant to index k, rr_ptr <= next RR index after k, with wrap. Otherwise rr_ptr holds.
- Starvation guard (HIPRI_EN=1, STARVE_LIMIT>0):
  - Increment starve_cnt on cycles where grant[0]=1 and any RR req is pending. Saturate at STARVE_LIMIT.
  - Clear starve_cnt on any RR grant, or when no RR req is pending.
  - force_rr = (starve_cnt == STARVE_LIMIT).
- Output stage, registered, 1-cycle latency from grant:
  - tx_wrvalid <= |grant.
  - When |grant=1: tx_hdr/tx_data <= slices of the granted index.
  - When |grant=0: tx_hdr/tx_data hold their previous values.
- Requestor handshake: a request is consumed in a cycle where grant[i]=1. Requestor i must present its next item, or drop req, in the following cycle. req is sampled every cycle and is never latched internally.
- Reset asserted mid-operation: any combinational grant in that cycle is suppressed. The registered write is not emitted, and tx_wrvalid=0 in the following cycle.
- N_REQ=2 with HIPRI_EN=1: the RR set has one member, and rr_ptr is constant.

Test Plan:
1. Reset, then hold all req=0 with tx_almostfull=0 -> can_issue=1 from cycle 2 after reset release; grant=0; tx_wrvalid=0 every cycle.
2. N_REQ=4, HIPRI_EN=1; req=4'b1110 held for 6 grants with distinct headers -> grant order 1,2,3,1,2,3. tx_hdr matches the granted slice one cycle later; tx_wrvalid=1 each cycle.
3. req=4'b0011 held, STARVE_LIMIT=8 -> grant[0] for 8 cycles, then grant[1] once, then grant[0] again. starve_cnt returns to 0 after the RR grant.
4. Assert tx_almostfull for 5 cycles while req=4'b0100 -> grant drops 1 cycle after almostfull rises and resumes 1 cycle after it falls. tx_wrvalid=0 for exactly 5 cycles.
5. HIPRI_EN=0, req=4'b1111 -> grants rotate 0,1,2,3,0. Dropping req[2] mid-sequence causes it to be skipped with no idle cycle.
6. Pull reset_n low for 1 cycle during continuous grants -> tx_wrvalid=0 the next cycle, rr_ptr=0, can_issue=0; arbitration restarts from index 1 (HIPRI_EN=1).
